seq_det_1011: RTL and testbench
===============================

SEQ_DET_1011 -- requirements
Module: seq_det_1011

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL consume the serial bit stream produced by the upstream D flip-flop stage (its q output) and detect the pattern 1011.
REQ-003 Parameter OVERLAP, default 1, SHALL select detection mode: 1 = overlapping, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8, SHALL set the width of the match counter.
REQ-005 Port clk, input, 1, SHALL be the rising-edge clock for all state.
REQ-006 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-007 Port din, input, 1, SHALL be the serial data bit.
REQ-008 Port din_valid, input, 1, SHALL qualify din; the bit is consumed on the edge where din_valid=1.
REQ-009 Port match, output, 1, SHALL be a registered one-cycle pulse indicating that a complete pattern was detected.
REQ-010 Port match_cnt, output, CNT_W, SHALL hold the saturating count of detected patterns; this port exists only with the configuration macro defined.

Function
REQ-011 The block SHALL be a Moore FSM with states IDLE, S1, S10, S101, S1011.
REQ-012 When din_valid=1, the state SHALL advance on the clock edge as follows:
- IDLE: din=1 -> S1; din=0 -> IDLE
- S1: 1 -> S1; 0 -> S10
- S10: 1 -> S101; 0 -> IDLE
- S101: 1 -> S1011; 0 -> S10
REQ-013 From S1011 with OVERLAP=1: 1 -> S1; 0 -> S10.
REQ-014 From S1011 with OVERLAP=0: 1 -> S1; 0 -> IDLE.
REQ-015 When din_valid=0, the state SHALL hold, and no bit SHALL be consumed.
REQ-016 match SHALL be 1 only in the cycle immediately after the edge that moves the FSM into S1011.
REQ-017 match SHALL be 0 in all other cycles, including stalled cycles while the FSM remains in S1011.
REQ-018 Latency SHALL be one cycle: the match pulse appears in the cycle after the edge that samples the final 1 of the pattern.
REQ-019 din and din_valid SHALL be treated as 0/1 only; X/Z handling is not required.

Reset
REQ-020 When rst=1 at a clock edge, the FSM SHALL go to IDLE and match SHALL be 0, regardless of din_valid.
REQ-021 When rst=1 at a clock edge, match_cnt SHALL be set to 0.
REQ-022 Reset SHALL take priority over a simultaneous completing bit: no match is produced and the count is not incremented.
REQ-023 Asserting reset in the middle of a pattern SHALL discard the partial pattern; detection restarts from IDLE.

Configuration
REQ-024 With macro SEQ_DET_MATCH_CNT_EN defined, port match_cnt and the counter SHALL exist.
REQ-025 The counter SHALL increment by 1 on each cycle where match=1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-026 Without SEQ_DET_MATCH_CNT_EN, the match_cnt port and counter logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-027 A shared package seq_det_pkg SHALL hold the FSM state typedef (3-bit encoding, IDLE=0) and the constant PATTERN = 4'b1011.
REQ-028 The saturating counter SHALL be a sub-module named sat_counter (parameter W; inputs clk, rst, inc; output cnt), instantiated only under SEQ_DET_MATCH_CNT_EN.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then din=1,0,1,1 with din_valid=1 -> match=1 exactly one cycle after the 4th edge; match_cnt=1.
- Stream 1,0,1,1,0,1,1 with OVERLAP=1 -> two match pulses, after bits 4 and 7; with OVERLAP=0 -> one pulse, after bit 4.
- din=1,0, then din_valid=0 for 3 cycles with din toggling, then 1,1 -> one match after the final bit; no match during the stall.
- din=1,0,1, rst=1 for one cycle, then 1 -> no match; state=S1 after the final bit.
- CNT_W=2, five non-adjacent 1011 patterns -> match_cnt sequence 1,2,3,3,3.
- Completing 1 sampled on the same edge as rst=1 -> match stays 0 and match_cnt stays 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the 1011 serial pattern detector.
//   state_t      - FSM state encoding (3 bits, IDLE = 0)
//   PATTERN      - the detected bit pattern, MSB received first
//   expected_bit - next pattern bit that advances the FSM from a given state
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

  // S1011 has no "expected" bit; its exits are handled explicitly by the FSM.
  function automatic logic expected_bit(input state_t s);
    logic b;
    b = 1'b0;
    case (s)
      IDLE:    b = PATTERN[3];
      S1:      b = PATTERN[2];
      S10:     b = PATTERN[1];
      S101:    b = PATTERN[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seq_det_1011_sat_counter.sv
// sat_counter: W-bit up-counter that saturates at all-ones.
//   clk - rising-edge clock
//   rst - synchronous active-high clear
//   inc - increment request for this cycle
//   cnt - current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_det_1011.sv
// seq_det_1011: detects the serial pattern 1011 on a qualified bit stream.
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   din       - serial data bit (consumed when din_valid = 1)
//   din_valid - qualifies din
//   match     - registered one-cycle pulse after the completing bit
//   match_cnt - saturating match count (only with SEQ_DET_MATCH_CNT_EN)
// Parameters: OVERLAP (1 = overlapping detection), CNT_W (counter width).
// Configuration macro: SEQ_DET_MATCH_CNT_EN enables match_cnt and its counter.
module seq_det_1011
  import seq_det_pkg::*;
#(
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             match
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  state_t r_state;
  state_t w_next;
  logic   w_hit;
  logic   r_match;

  always_comb begin
    w_next = r_state;
    w_hit  = (din == expected_bit(r_state));
    if (din_valid) begin
      case (r_state)
        IDLE:    w_next = w_hit ? S1   : IDLE;
        S1:      w_next = w_hit ? S10  : S1;
        S10:     w_next = w_hit ? S101 : IDLE;
        S101:    w_next = w_hit ? S1011 : S10;
        S1011: begin
          if (din)               w_next = S1;
          else if (OVERLAP != 0) w_next = S10;
          else                   w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // S1011 is only entered by consuming a bit, so qualifying with din_valid
  // keeps match low while stalled in S1011.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_match <= 1'b0;
    end else begin
      r_state <= w_next;
      r_match <= din_valid && (w_next == S1011);
    end
  end

  assign match = r_match;

`ifdef SEQ_DET_MATCH_CNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(r_match),
    .cnt(match_cnt)
  );
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_seq_det_1011.sv
module tb_seq_det_1011;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic m_ov, m_nov, m_c2;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [7:0] c_ov, c_nov;
  logic [1:0] c_c2;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_det_1011 u_ov (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .match(m_ov)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(c_ov)
`endif
  );

  seq_det_1011 #(.OVERLAP(0)) u_nov (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .match(m_nov)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(c_nov)
`endif
  );

  seq_det_1011 #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .match(m_c2)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(c_c2)
`endif
  );

  task automatic step(input logic r, input logic v, input logic b);
    @(negedge clk);
    rst = r;
    din_valid = v;
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // eo: expected match for the overlapping instances, en: non-overlapping
  task automatic chk_m(input string tag, input logic eo, input logic en);
    chk({tag, "/ov"},  {7'd0, m_ov},  {7'd0, eo});
    chk({tag, "/c2"},  {7'd0, m_c2},  {7'd0, eo});
    chk({tag, "/nov"}, {7'd0, m_nov}, {7'd0, en});
  endtask

  initial begin
    // Reset with valid data present
    step(1, 1, 1);
    step(1, 1, 1);
    chk_m("reset", 0, 0);
    chk("reset_state", 8'(u_ov.r_state), 8'(IDLE));
`ifdef SEQ_DET_MATCH_CNT_EN
    chk("reset_cnt", c_ov, 8'd0);
`endif

    // Basic 1011
    step(0, 1, 1); chk_m("basic_b1", 0, 0);
    step(0, 1, 0); chk_m("basic_b2", 0, 0);
    step(0, 1, 1); chk_m("basic_b3", 0, 0);
    step(0, 1, 1); chk_m("basic_b4", 1, 1);
    step(0, 0, 0); chk_m("basic_after", 0, 0);
`ifdef SEQ_DET_MATCH_CNT_EN
    chk("basic_cnt", c_ov, 8'd1);
`endif

    // Overlap vs non-overlap: 1,0,1,1,0,1,1
    step(1, 0, 0); chk_m("ovl_rst", 0, 0);
    step(0, 1, 1); chk_m("ovl_b1", 0, 0);
    step(0, 1, 0); chk_m("ovl_b2", 0, 0);
    step(0, 1, 1); chk_m("ovl_b3", 0, 0);
    step(0, 1, 1); chk_m("ovl_b4", 1, 1);
    step(0, 1, 0); chk_m("ovl_b5", 0, 0);
    step(0, 1, 1); chk_m("ovl_b6", 0, 0);
    step(0, 1, 1); chk_m("ovl_b7", 1, 0);
    // Stalled in S1011 (ov instances): match must drop
    step(0, 0, 1); chk_m("ovl_stall", 0, 0);
    step(0, 0, 0); chk_m("ovl_stall2", 0, 0);

    // Stall mid-pattern with din toggling
    step(1, 0, 0); chk_m("stall_rst", 0, 0);
    step(0, 1, 1); chk_m("stall_b1", 0, 0);
    step(0, 1, 0); chk_m("stall_b2", 0, 0);
    step(0, 0, 1); chk_m("stall_s1", 0, 0);
    step(0, 0, 0); chk_m("stall_s2", 0, 0);
    step(0, 0, 1); chk_m("stall_s3", 0, 0);
    step(0, 1, 1); chk_m("stall_b3", 0, 0);
    step(0, 1, 1); chk_m("stall_b4", 1, 1);
    step(0, 0, 1); chk_m("stall_after", 0, 0);

    // Reset mid-pattern discards partial pattern
    step(1, 0, 0); chk_m("mid_rst0", 0, 0);
    step(0, 1, 1); chk_m("mid_b1", 0, 0);
    step(0, 1, 0); chk_m("mid_b2", 0, 0);
    step(0, 1, 1); chk_m("mid_b3", 0, 0);
    step(1, 1, 1); chk_m("mid_rst", 0, 0);
    step(0, 1, 1); chk_m("mid_b4", 0, 0);
    chk("mid_state", 8'(u_ov.r_state), 8'(S1));
    chk("mid_state_nov", 8'(u_nov.r_state), 8'(S1));
    step(0, 1, 0); chk_m("mid_b5", 0, 0);
    step(0, 1, 1); chk_m("mid_b6", 0, 0);
    step(0, 1, 1); chk_m("mid_b7", 1, 1);

    // Five separated patterns; CNT_W=2 instance saturates at 3
    step(1, 0, 0); chk_m("sat_rst", 0, 0);
    for (int unsigned k = 0; k < 5; k++) begin
      step(0, 1, 1); chk_m("sat_b1", 0, 0);
      step(0, 1, 0); chk_m("sat_b2", 0, 0);
      step(0, 1, 1); chk_m("sat_b3", 0, 0);
      step(0, 1, 1); chk_m("sat_b4", 1, 1);
      step(0, 1, 0); chk_m("sat_g1", 0, 0);
`ifdef SEQ_DET_MATCH_CNT_EN
      chk("sat_cnt_c2", {6'd0, c_c2}, (k < 2) ? 8'(k + 1) : 8'd3);
      chk("sat_cnt_ov", c_ov, 8'(k + 1));
`endif
      step(0, 1, 0); chk_m("sat_g2", 0, 0);
    end

    // Completing bit on the same edge as reset
    step(1, 0, 0); chk_m("race_rst0", 0, 0);
    step(0, 1, 1); chk_m("race_b1", 0, 0);
    step(0, 1, 0); chk_m("race_b2", 0, 0);
    step(0, 1, 1); chk_m("race_b3", 0, 0);
    step(1, 1, 1); chk_m("race_b4", 0, 0);
    chk("race_state", 8'(u_ov.r_state), 8'(IDLE));
    step(0, 0, 0); chk_m("race_after", 0, 0);
`ifdef SEQ_DET_MATCH_CNT_EN
    chk("race_cnt_ov", c_ov, 8'd0);
    chk("race_cnt_c2", {6'd0, c_c2}, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
